// File: rtl/wb_burst_master.sv
// Pipelined Wishbone burst master.
//
// Turns one command (direction, start word address, word count - 1) into a burst of
// single-word pipelined WB requests. Write words come in on a valid/ready stream and
// read words leave on a valid-only stream. A burst ends when every accepted request
// has been acknowledged (o_done), or aborts with o_done + o_error when the bus makes
// no progress for ACK_TIMEOUT cycles.
//
// Ports:
//   i_clk, i_rst_n               clock (posedge), asynchronous active-low reset
//   i_cmd_*/o_cmd_ready          command handshake, accepted only in idle
//   i_wdata*/o_wdata_ready       write-word stream
//   o_rdata_valid/o_rdata        read-word stream, single-cycle, no backpressure
//   o_done/o_error               end-of-burst pulse, error marks a timeout abort
//   o_wb_*/i_wb_*                pipelined Wishbone master signals, all outputs registered
module wb_burst_master #(
  parameter int unsigned WB_ADDR_WIDTH   = 6,
  parameter int unsigned LEN_WIDTH       = 8,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ACK_TIMEOUT     = 255
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic                     i_cmd_we,
  input  logic [WB_ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [LEN_WIDTH-1:0]     i_cmd_len,
  input  logic                     i_wdata_valid,
  output logic                     o_wdata_ready,
  input  logic [31:0]              i_wdata,
  output logic                     o_rdata_valid,
  output logic [31:0]              o_rdata,
  output logic                     o_done,
  output logic                     o_error,
  output logic                     o_wb_cyc,
  output logic                     o_wb_stb,
  input  logic                     i_wb_stall,
  input  logic                     i_wb_ack,
  output logic                     o_wb_we,
  output logic [WB_ADDR_WIDTH-1:0] o_wb_addr,
  output logic [31:0]              o_wb_data,
  output logic [3:0]               o_wb_sel,
  input  logic [31:0]              i_wb_data
);

  localparam int unsigned RemW = LEN_WIDTH + 1;
  localparam int unsigned OutW = 4;
  localparam int unsigned ToW  = 8;

  typedef enum logic [1:0] {StIdle, StReq, StDrain} state_e;

  state_e                   state_q, state_d;
  logic                     we_q, we_d;
  logic                     cyc_q, cyc_d;
  logic                     stb_q, stb_d;
  logic [WB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]              wb_data_q, wb_data_d;
  logic [RemW-1:0]          remaining_q, remaining_d;
  logic [OutW-1:0]          outstanding_q, outstanding_d;
  logic [ToW-1:0]           timeout_q, timeout_d;
  logic                     rvalid_q, rvalid_d;
  logic [31:0]              rdata_q, rdata_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;

  logic            accept;
  logic            any_ack;
  logic            ack_v;
  logic [OutW-1:0] out_upd;
  logic            timeout_hit;
  logic            slot_free;
  logic            load;
  logic            wait_wdata;

  assign accept  = stb_q && !i_wb_stall;
  assign any_ack = cyc_q && i_wb_ack;
  // An ack with nothing outstanding is stray and must not move any state.
  assign ack_v   = any_ack && (outstanding_q != '0);
  assign out_upd = outstanding_q + OutW'(accept) - OutW'(ack_v);

  assign timeout_hit = (state_q != StIdle) && (timeout_q == ToW'(ACK_TIMEOUT));

  // A new request may be loaded when the STB slot is empty (or empties this cycle),
  // words remain, and the window still has room after this cycle's accept/ack.
  assign slot_free = (state_q == StReq) && !timeout_hit && (!stb_q || accept) &&
                     (remaining_q != '0) && (out_upd < OutW'(MAX_OUTSTANDING));
  assign load      = slot_free && (!we_q || i_wdata_valid);

  // Write burst idle on the bus, blocked only by the data source: not a bus timeout.
  assign wait_wdata = (state_q == StReq) && we_q && !stb_q && (outstanding_q == '0);

  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    cyc_d         = cyc_q;
    stb_d         = stb_q;
    addr_d        = addr_q;
    wb_data_d     = wb_data_q;
    remaining_d   = remaining_q;
    outstanding_d = out_upd;
    timeout_d     = timeout_q;
    rvalid_d      = ack_v && !we_q;
    rdata_d       = (ack_v && !we_q) ? i_wb_data : rdata_q;
    done_d        = 1'b0;
    error_d       = 1'b0;

    if (accept) begin
      addr_d = addr_q + WB_ADDR_WIDTH'(1);
      stb_d  = 1'b0;
    end
    if (load) begin
      stb_d       = 1'b1;
      remaining_d = remaining_q - RemW'(1);
      if (we_q) begin
        wb_data_d = i_wdata;
      end
    end

    if ((state_q == StIdle) || accept || any_ack) begin
      timeout_d = '0;
    end else if (cyc_q && !wait_wdata && (timeout_q != ToW'(ACK_TIMEOUT))) begin
      timeout_d = timeout_q + ToW'(1);
    end

    unique case (state_q)
      StIdle: begin
        outstanding_d = '0;
        if (i_cmd_valid) begin
          state_d     = StReq;
          we_d        = i_cmd_we;
          cyc_d       = 1'b1;
          stb_d       = 1'b0;
          addr_d      = i_cmd_addr;
          remaining_d = {1'b0, i_cmd_len} + RemW'(1);
        end
      end
      StReq: begin
        if (timeout_hit) begin
          state_d       = StIdle;
          cyc_d         = 1'b0;
          stb_d         = 1'b0;
          outstanding_d = '0;
          done_d        = 1'b1;
          error_d       = 1'b1;
        end else if ((remaining_d == '0) && !stb_d) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (timeout_hit) begin
          state_d       = StIdle;
          cyc_d         = 1'b0;
          stb_d         = 1'b0;
          outstanding_d = '0;
          done_d        = 1'b1;
          error_d       = 1'b1;
        end else if (outstanding_q == '0) begin
          // Registered count: done lands one cycle after the last read word.
          state_d = StIdle;
          cyc_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= StIdle;
      we_q          <= 1'b0;
      cyc_q         <= 1'b0;
      stb_q         <= 1'b0;
      addr_q        <= '0;
      wb_data_q     <= '0;
      remaining_q   <= '0;
      outstanding_q <= '0;
      timeout_q     <= '0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      cyc_q         <= cyc_d;
      stb_q         <= stb_d;
      addr_q        <= addr_d;
      wb_data_q     <= wb_data_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      timeout_q     <= timeout_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  assign o_cmd_ready   = (state_q == StIdle);
  assign o_wdata_ready = we_q && slot_free;
  assign o_rdata_valid = rvalid_q;
  assign o_rdata       = rdata_q;
  assign o_done        = done_q;
  assign o_error       = error_q;
  assign o_wb_cyc      = cyc_q;
  assign o_wb_stb      = stb_q;
  assign o_wb_we       = we_q;
  assign o_wb_addr     = addr_q;
  assign o_wb_data     = wb_data_q;
  assign o_wb_sel      = 4'b1111;

endmodule

// File: tb/tb_wb_burst_master.sv
// Scoreboard bench for wb_burst_master: a pipelined slave model with configurable stall
// and ack latency, a write-data source, and a monitor that checks every bus acceptance,
// read word and done pulse against expectations queued by the test sequence.
module tb_wb_burst_master;
  localparam int unsigned AW   = 6;
  localparam int unsigned LW   = 8;
  localparam int unsigned MAXO = 4;
  localparam int unsigned TMO  = 20;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic          i_cmd_we;
  logic [AW-1:0] i_cmd_addr;
  logic [LW-1:0] i_cmd_len;
  logic          i_wdata_valid;
  logic          o_wdata_ready;
  logic [31:0]   i_wdata;
  logic          o_rdata_valid;
  logic [31:0]   o_rdata;
  logic          o_done;
  logic          o_error;
  logic          o_wb_cyc;
  logic          o_wb_stb;
  logic          i_wb_stall;
  logic          i_wb_ack;
  logic          o_wb_we;
  logic [AW-1:0] o_wb_addr;
  logic [31:0]   o_wb_data;
  logic [3:0]    o_wb_sel;
  logic [31:0]   i_wb_data;

  wb_burst_master #(
    .WB_ADDR_WIDTH  (AW),
    .LEN_WIDTH      (LW),
    .MAX_OUTSTANDING(MAXO),
    .ACK_TIMEOUT    (TMO)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_cmd_valid  (i_cmd_valid),
    .o_cmd_ready  (o_cmd_ready),
    .i_cmd_we     (i_cmd_we),
    .i_cmd_addr   (i_cmd_addr),
    .i_cmd_len    (i_cmd_len),
    .i_wdata_valid(i_wdata_valid),
    .o_wdata_ready(o_wdata_ready),
    .i_wdata      (i_wdata),
    .o_rdata_valid(o_rdata_valid),
    .o_rdata      (o_rdata),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_wb_cyc     (o_wb_cyc),
    .o_wb_stb     (o_wb_stb),
    .i_wb_stall   (i_wb_stall),
    .i_wb_ack     (i_wb_ack),
    .o_wb_we      (o_wb_we),
    .o_wb_addr    (o_wb_addr),
    .o_wb_data    (o_wb_data),
    .o_wb_sel     (o_wb_sel),
    .i_wb_data    (i_wb_data)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          we;
  } acc_t;
  typedef struct packed {
    logic [31:0] data;
    int          rdy;
  } pend_t;
  typedef struct packed {
    logic err;
    logic rd;
  } done_t;

  acc_t        exp_acc[$];
  logic [31:0] exp_rd[$];
  done_t       exp_done[$];
  logic [31:0] wq[$];
  pend_t       pend[$];
  logic [31:0] mem[64];

  int tests = 0;
  int fails = 0;

  // Slave / source configuration, changed only while the master is idle.
  int   stall_cfg = 0;
  int   ack_dly   = 0;
  logic ack_en    = 1'b1;
  logic w_toggle  = 1'b0;
  logic force_ack = 1'b0;

  // Monitor statistics.
  int acc_cnt  = 0;
  int rv_cnt   = 0;
  int done_cnt = 0;
  int mon_out  = 0;
  int max_out  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_acc(input logic [AW-1:0] a, input logic [31:0] d, input logic we);
    acc_t e;
    e.addr = a;
    e.data = d;
    e.we   = we;
    exp_acc.push_back(e);
  endtask

  task automatic push_done(input logic err, input logic rd);
    done_t e;
    e.err = err;
    e.rd  = rd;
    exp_done.push_back(e);
  endtask

  // Slave model and write-data source; inputs change just after the falling edge.
  initial begin
    int          bcyc;
    int          stall_cnt;
    logic        w_take;
    logic        w_phase;
    logic [31:0] tmp;
    pend_t       p;
    bcyc = 0; stall_cnt = 0; w_take = 1'b0; w_phase = 1'b0;
    i_wdata_valid = 1'b0; i_wdata = '0;
    i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_data = '0;
    forever begin
      @(negedge i_clk);
      bcyc++;
      if (w_take && wq.size() > 0) tmp = wq.pop_front();
      w_phase       = ~w_phase;
      i_wdata_valid = (wq.size() > 0) && (!w_toggle || w_phase);
      i_wdata       = (wq.size() > 0) ? wq[0] : 32'h0;
      if (!o_wb_cyc) pend.delete();
      i_wb_ack = 1'b0;
      if (force_ack) begin
        i_wb_ack  = 1'b1;
        i_wb_data = 32'hBAD0BAD0;
        force_ack = 1'b0;
      end else if (ack_en && pend.size() > 0 && bcyc >= pend[0].rdy) begin
        p         = pend.pop_front();
        i_wb_ack  = 1'b1;
        i_wb_data = p.data;
      end
      i_wb_stall = 1'b0;
      if (o_wb_stb) begin
        if (stall_cnt < stall_cfg) begin
          i_wb_stall = 1'b1;
          stall_cnt++;
        end else begin
          stall_cnt = 0;
          if (o_wb_we) mem[o_wb_addr] = o_wb_data;
          p.data = o_wb_we ? 32'h0 : mem[o_wb_addr];
          p.rdy  = bcyc + 1 + ack_dly;
          pend.push_back(p);
        end
      end
      #1 w_take = i_wdata_valid && o_wdata_ready;
    end
  end

  // Monitor: pops expectations whenever the DUT presents an acceptance, word or done.
  initial begin
    int            mcyc;
    int            last_acc;
    logic          prev_st;
    logic          prev_rv;
    logic [AW-1:0] p_addr;
    logic [31:0]   p_data;
    logic          p_we;
    logic          acc;
    acc_t          ea;
    done_t         ed;
    logic [31:0]   er;
    mcyc = 0; last_acc = 0; prev_st = 1'b0; prev_rv = 1'b0;
    p_addr = '0; p_data = '0; p_we = 1'b0;
    forever begin
      @(negedge i_clk);
      #2;
      mcyc++;
      if (!i_rst_n) begin
        prev_st = 1'b0;
        prev_rv = 1'b0;
        mon_out = 0;
      end else begin
        if (prev_st) begin
          chk("stall_hold_stb", {31'h0, o_wb_stb}, 32'h1);
          chk("stall_hold_addr", 32'(o_wb_addr), 32'(p_addr));
          chk("stall_hold_data", o_wb_data, p_data);
          chk("stall_hold_we", {31'h0, o_wb_we}, {31'h0, p_we});
        end
        prev_st = o_wb_stb && i_wb_stall;
        p_addr  = o_wb_addr;
        p_data  = o_wb_data;
        p_we    = o_wb_we;
        acc     = o_wb_stb && !i_wb_stall;
        if (acc) begin
          acc_cnt++;
          last_acc = mcyc;
          if (exp_acc.size() == 0) begin
            chk("unexpected_accept_addr", 32'(o_wb_addr), 32'hFFFF_FFFF);
          end else begin
            ea = exp_acc.pop_front();
            chk("accept_addr", 32'(o_wb_addr), 32'(ea.addr));
            chk("accept_we", {31'h0, o_wb_we}, {31'h0, ea.we});
            if (ea.we) chk("accept_wdata", o_wb_data, ea.data);
          end
        end
        if (!o_wb_cyc) mon_out = 0;
        else if (i_wb_ack && mon_out > 0) mon_out--;
        if (acc) mon_out++;
        if (mon_out > max_out) max_out = mon_out;
        if (o_rdata_valid) begin
          rv_cnt++;
          if (exp_rd.size() == 0) begin
            chk("unexpected_rdata_valid", o_rdata, 32'hFFFF_FFFF);
          end else begin
            er = exp_rd.pop_front();
            chk("rdata", o_rdata, er);
          end
        end
        if (o_done) begin
          done_cnt++;
          if (exp_done.size() == 0) begin
            chk("unexpected_done", {31'h0, o_done}, 32'h0);
          end else begin
            ed = exp_done.pop_front();
            chk("done_error", {31'h0, o_error}, {31'h0, ed.err});
            chk("done_cyc_low", {31'h0, o_wb_cyc}, 32'h0);
            if (ed.rd) chk("done_after_last_rvalid", {31'h0, prev_rv}, 32'h1);
            if (ed.err) begin
              chk("timeout_latency_in_window",
                  32'((mcyc - last_acc) >= int'(TMO) && (mcyc - last_acc) <= int'(TMO) + 3), 32'h1);
            end
          end
        end else if (o_error) begin
          chk("error_without_done", {31'h0, o_error}, 32'h0);
        end
        prev_rv = o_rdata_valid;
      end
    end
  end

  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    int n;
    n = 0;
    @(negedge i_clk);
    while (!o_cmd_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    #3;
    i_cmd_valid = 1'b1;
    i_cmd_we    = we;
    i_cmd_addr  = addr;
    i_cmd_len   = len;
    @(negedge i_clk);
    #3 i_cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < 1000) begin
      @(negedge i_clk);
      n++;
    end
    chk({name, "_done_seen"}, 32'(done_cnt != d0), 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, fails so far %0d", fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0;
    int r0;
    int d0;
    int n;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[5] = 32'hDEADBEEF;
    i_rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_we = 1'b0; i_cmd_addr = '0; i_cmd_len = '0;
    repeat (3) @(negedge i_clk);
    #2;
    chk("rst_cyc", {31'h0, o_wb_cyc}, 32'h0);
    chk("rst_stb", {31'h0, o_wb_stb}, 32'h0);
    chk("rst_we", {31'h0, o_wb_we}, 32'h0);
    chk("rst_addr", 32'(o_wb_addr), 32'h0);
    chk("rst_wdata", o_wb_data, 32'h0);
    chk("rst_rvalid", {31'h0, o_rdata_valid}, 32'h0);
    chk("rst_rdata", o_rdata, 32'h0);
    chk("rst_done_error", {30'h0, o_done, o_error}, 32'h0);
    chk("rst_cmd_ready", {31'h0, o_cmd_ready}, 32'h1);
    chk("rst_sel", {28'h0, o_wb_sel}, 32'hF);
    i_rst_n = 1'b1;

    // 1: single read with stalls and ack wait states.
    stall_cfg = 2; ack_dly = 2;
    push_acc(6'd5, 32'h0, 1'b0);
    exp_rd.push_back(32'hDEADBEEF);
    push_done(1'b0, 1'b1);
    a0 = acc_cnt;
    issue(1'b0, 6'd5, 8'd0);
    wait_done("t1");
    chk("t1_accepts", 32'(acc_cnt - a0), 32'd1);
    @(negedge i_clk);
    chk("t1_cyc_low_after", {31'h0, o_wb_cyc}, 32'h0);

    // 2: 8-word write wrapping the address space.
    stall_cfg = 0; ack_dly = 0;
    for (int i = 0; i < 8; i++) begin
      wq.push_back(32'(i + 1));
      push_acc(6'(60 + i), 32'(i + 1), 1'b1);
    end
    push_done(1'b0, 1'b0);
    a0 = acc_cnt;
    issue(1'b1, 6'd60, 8'd7);
    wait_done("t2");
    chk("t2_accepts", 32'(acc_cnt - a0), 32'd8);
    for (int i = 0; i < 8; i++) chk("t2_mem", mem[6'(60 + i)], 32'(i + 1));

    // 3: write with a gappy data source and one stall per request.
    stall_cfg = 1; w_toggle = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wq.push_back(32'h5500_0001 + 32'(i));
      push_acc(6'(48 + i), 32'h5500_0001 + 32'(i), 1'b1);
    end
    push_done(1'b0, 1'b0);
    a0 = acc_cnt;
    issue(1'b1, 6'd48, 8'd3);
    wait_done("t3");
    chk("t3_accepts", 32'(acc_cnt - a0), 32'd4);
    for (int i = 0; i < 4; i++) chk("t3_mem", mem[6'(48 + i)], 32'h5500_0001 + 32'(i));
    w_toggle = 1'b0; stall_cfg = 0;

    // 4: 16-word read against a slow-acking slave, window limited to MAXO.
    ack_dly = 10; max_out = 0;
    for (int i = 0; i < 16; i++) begin
      push_acc(6'(8 + i), 32'h0, 1'b0);
      exp_rd.push_back(32'hA000_0008 + 32'(i));
    end
    push_done(1'b0, 1'b1);
    a0 = acc_cnt; r0 = rv_cnt;
    issue(1'b0, 6'd8, 8'd15);
    wait_done("t4");
    chk("t4_accepts", 32'(acc_cnt - a0), 32'd16);
    chk("t4_rvalid_count", 32'(rv_cnt - r0), 32'd16);
    chk("t4_max_outstanding", 32'(max_out), 32'(MAXO));

    // 5: slave never acks -> timeout abort, then a stray ack is ignored.
    ack_en = 1'b0; ack_dly = 0;
    for (int i = 0; i < 4; i++) push_acc(6'(32 + i), 32'h0, 1'b0);
    push_done(1'b1, 1'b0);
    a0 = acc_cnt;
    issue(1'b0, 6'd32, 8'd3);
    wait_done("t5");
    chk("t5_accepts", 32'(acc_cnt - a0), 32'd4);
    r0 = rv_cnt;
    @(negedge i_clk);
    #3 force_ack = 1'b1;
    repeat (4) @(negedge i_clk);
    chk("t5_late_ack_no_rvalid", 32'(rv_cnt - r0), 32'd0);
    ack_en = 1'b1;

    // 6: reset pulse in the middle of a write burst.
    ack_dly = 3;
    for (int i = 0; i < 8; i++) begin
      wq.push_back(32'h100 + 32'(i));
      push_acc(6'(40 + i), 32'h100 + 32'(i), 1'b1);
    end
    a0 = acc_cnt;
    issue(1'b1, 6'd40, 8'd7);
    n = 0;
    while ((acc_cnt - a0) < 3 && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    chk("t6_partial_accepts", 32'((acc_cnt - a0) >= 3), 32'h1);
    d0 = done_cnt;
    #3 i_rst_n = 1'b0;
    #1;
    chk("t6_cyc_async_low", {31'h0, o_wb_cyc}, 32'h0);
    chk("t6_stb_async_low", {31'h0, o_wb_stb}, 32'h0);
    exp_acc.delete(); exp_rd.delete(); exp_done.delete(); wq.delete();
    @(negedge i_clk);
    #3 i_rst_n = 1'b1;
    #1 chk("t6_cmd_ready_after", {31'h0, o_cmd_ready}, 32'h1);
    repeat (5) @(negedge i_clk);
    chk("t6_no_done", 32'(done_cnt - d0), 32'd0);

    // 7: normal read after reset, wrapping across the top of memory.
    ack_dly = 1;
    for (int i = 0; i < 4; i++) begin
      push_acc(6'(62 + i), 32'h0, 1'b0);
      exp_rd.push_back(32'(i + 3));
    end
    push_done(1'b0, 1'b1);
    a0 = acc_cnt;
    issue(1'b0, 6'd62, 8'd3);
    wait_done("t7");
    chk("t7_accepts", 32'(acc_cnt - a0), 32'd4);

    repeat (3) @(negedge i_clk);
    chk("left_exp_accepts", 32'(exp_acc.size()), 32'd0);
    chk("left_exp_rdata", 32'(exp_rd.size()), 32'd0);
    chk("left_exp_done", 32'(exp_done.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
